ula_seq: RTL and testbench

- Parametrised, clocked successor of the 8-bit combinational ULA.
- Operand width is set by WIDTH; the result is 2*WIDTH.
- Multiplication is a multi-cycle shift-add; all other ops complete in one cycle.
- Operands enter through a valid/ready handshake; result and flags are held in registers behind a second valid/ready handshake. This lets the block sit between a register file and a writeback stage.

---
 rtl/ula_seq.sv | 139 +++++++++++++
 tb/tb_ula_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Clocked ALU with operand and result valid/ready handshakes.
// Multiplication is a WIDTH-iteration shift-add; every other op completes in one cycle.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           selectors,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero_flag,
    output logic                 sign_flag,
    output logic                 err_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_EQ   = 4'd8;
    localparam logic [3:0] OP_GTE  = 4'd9;
    localparam logic [3:0] OP_LTE  = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     acc;
    logic [RW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [RW-1:0]     acc_step;
    logic [RW-1:0]     alu_res;
    logic              alu_err;
    logic [RW-1:0]     a_ext;
    logic [RW-1:0]     b_ext;
    logic              accept;
    logic              mul_last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (state == MUL) && (cnt == CW'(WIDTH - 1));

    assign a_ext    = {{WIDTH{1'b0}}, a};
    assign b_ext    = {{WIDTH{1'b0}}, b};
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    // Single-cycle operations; subtraction at 2*WIDTH bits yields the sign extension directly.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (selectors)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, a | b};
            OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(a & b)};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, a ^ b};
            OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(a | b)};
            OP_EQ:   alu_res = {{(RW-1){1'b0}}, (a == b)};
            OP_GTE:  alu_res = {{(RW-1){1'b0}}, (a >= b)};
            OP_LTE:  alu_res = {{(RW-1){1'b0}}, (a <= b)};
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (selectors == OP_MUL) ? MUL : DONE;
            MUL:  if (mul_last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            zero_flag <= 1'b1;
            sign_flag <= 1'b0;
            err_flag  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else if (accept) begin
            if (selectors == OP_MUL) begin
                acc    <= '0;
                mcand  <= a_ext;
                mplier <= b;
                cnt    <= '0;
            end else begin
                result    <= alu_res;
                zero_flag <= (alu_res == '0);
                sign_flag <= alu_res[RW-1];
                err_flag  <= alu_err;
            end
        end else if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            // Last iteration: publish the sum including this cycle's partial product.
            if (mul_last) begin
                result    <= acc_step;
                zero_flag <= (acc_step == '0);
                sign_flag <= acc_step[RW-1];
                err_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq at WIDTH=8: opcode table plus backpressure and reset-abort sequences.
module tb_ula_seq;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  selectors;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic        zero_flag;
    logic        sign_flag;
    logic        err_flag;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks;
    int failures;

    ula_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .selectors(selectors),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .zero_flag(zero_flag), .sign_flag(sign_flag), .err_flag(err_flag),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] res;
        logic        z;
        logic        s;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op with out_ready high; return at the negedge where out_valid is first seen.
    task automatic run_op(input logic [3:0] sel, input logic [7:0] va, input logic [7:0] vb,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        selectors = sel; a = va; b = vb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; selectors = 4'd0;
        lat = 1;
        busy_ok = busy;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok & busy;
        end
    endtask

    initial begin
        int lat;
        logic bok;
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; selectors = '0;

        vecs[0]  = '{4'd0,  8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'd1,  8'd5,   8'd7,   16'hFFFE, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'd1,  8'd9,   8'd9,   16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'd2,  8'd255, 8'd255, 16'hFE01, 1'b0, 1'b1, 1'b0, 9};
        vecs[4]  = '{4'd2,  8'd0,   8'd77,  16'h0000, 1'b1, 1'b0, 1'b0, 9};
        vecs[5]  = '{4'd5,  8'hFF,  8'hFF,  16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'd9,  8'd3,   8'd3,   16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'd10, 8'd4,   8'd3,   16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'd13, 8'd12,  8'd34,  16'h0000, 1'b1, 1'b0, 1'b1, 1};
        vecs[9]  = '{4'd0,  8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{4'd2,  8'd13,  8'd11,  16'h008F, 1'b0, 1'b0, 1'b0, 9};
        vecs[11] = '{4'd6,  8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{4'd7,  8'h0F,  8'hF0,  16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[13] = '{4'd3,  8'hAA,  8'h0F,  16'h000A, 1'b0, 1'b0, 1'b0, 1};
        vecs[14] = '{4'd4,  8'hA0,  8'h05,  16'h00A5, 1'b0, 1'b0, 1'b0, 1};
        vecs[15] = '{4'd8,  8'd7,   8'd7,   16'h0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[16] = '{4'd8,  8'd7,   8'd6,   16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[17] = '{4'd15, 8'd1,   8'd2,   16'h0000, 1'b1, 1'b0, 1'b1, 1};
        vecs[18] = '{4'd9,  8'd2,   8'd200, 16'h0000, 1'b1, 1'b0, 1'b0, 1};

        #12;
        check("reset_result", 32'(result), 32'h0);
        check("reset_flags", {zero_flag, sign_flag, err_flag}, 32'b100);
        check("reset_hs", {out_valid, in_ready, busy}, 32'b010);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].sel, vecs[i].va, vecs[i].vb, lat, bok);
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_flags", i), {zero_flag, sign_flag, err_flag},
                  {vecs[i].z, vecs[i].s, vecs[i].e});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), 32'(bok), 32'h1);
        end

        // Backpressure: add 1+1, hold out_ready low, poke in_valid with other operands.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(4'd0, 8'd1, 8'd1, lat, bok);
        check("bp_latency", lat, 1);
        for (int k = 0; k < 5; k++) begin
            selectors = 4'd2; a = 8'd9; b = 8'd9; in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp_hold%0d", k), {out_valid, in_ready, result}, {1'b1, 1'b0, 16'h0002});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {out_valid, in_ready, busy}, 32'b010);
        check("bp_retain", 32'(result), 32'h2);

        // Reset in the middle of 3*4.
        run_op(4'd0, 8'd0, 8'd0, lat, bok);
        @(negedge clk);
        selectors = 4'd2; a = 8'd3; b = 8'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mul_busy", {busy, out_valid}, 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'h0);
        check("abort_flags", {zero_flag, sign_flag, err_flag}, 32'b100);
        check("abort_hs", {out_valid, in_ready, busy}, 32'b010);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd0, 8'd2, 8'd2, lat, bok);
        check("post_reset_result", 32'(result), 32'h4);
        check("post_reset_flags", {zero_flag, sign_flag, err_flag}, 32'b000);
        check("post_reset_latency", lat, 1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
